// File: rtl/multicycle_pkg.sv
// Shared types and constants for the LEGv8 multicycle control FSM.
package multicycle_pkg;

  localparam int unsigned OPCODE_W = 11;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned WAIT_W   = 8;
  localparam int unsigned ALUOP_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_CBZ     = 3'd3,
    CLS_HALT    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } instr_class_e;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 11'h458;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 11'h658;
  localparam logic [OPCODE_W-1:0] OP_AND  = 11'h450;
  localparam logic [OPCODE_W-1:0] OP_ORR  = 11'h550;
  localparam logic [OPCODE_W-1:0] OP_LDUR = 11'h7C2;
  localparam logic [OPCODE_W-1:0] OP_STUR = 11'h7C0;
  localparam logic [OPCODE_W-1:0] OP_HALT = 11'h7FF;
  localparam logic [7:0]          OP_CBZ_PREFIX = 8'hB4;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_PASS  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

  // Datapath strobe bundle driven by the controller each cycle.
  typedef struct packed {
    logic               imem_req;
    logic               ir_write;
    logic               pc_write;
    logic               pc_src;
    logic               reg2loc;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
    logic               dmem_read;
    logic               dmem_write;
    logic               memtoreg;
    logic               regwrite;
  } ctrl_t;

  function automatic logic is_cbz(input logic [OPCODE_W-1:0] op);
    return op[OPCODE_W-1:3] == OP_CBZ_PREFIX;
  endfunction

endpackage

// File: rtl/instr_classifier.sv
// Combinational opcode decoder: maps instruction[31:21] to an instruction class.
module instr_classifier
  import multicycle_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output instr_class_e        instr_class
);

  always_comb begin
    instr_class = CLS_ILLEGAL;
    if (is_cbz(opcode)) begin
      instr_class = CLS_CBZ;
    end else begin
      unique case (opcode)
        OP_ADD, OP_SUB, OP_AND, OP_ORR: instr_class = CLS_RTYPE;
        OP_LDUR:                        instr_class = CLS_LOAD;
        OP_STUR:                        instr_class = CLS_STORE;
        OP_HALT:                        instr_class = CLS_HALT;
        default:                        instr_class = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle LEGv8 control FSM: sequences fetch/decode/execute/memory/writeback
// with variable-latency memory handshakes, stall timeout and sticky status.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg2loc,
  output logic                alusrc,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic                memtoreg,
  output logic                regwrite,
  output logic [STATE_W-1:0]  state,
  output logic                halted,
  output logic                illegal,
  output logic                timeout,
  output logic [CNT_W-1:0]    instr_count
);

  // Wait-counter value at which a still-unanswered request gives up.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STALL_LIMIT - 1);

  state_e           state_q, state_d;
  instr_class_e     cls_q, cls_d, dec_class;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] count_q;
  logic             halted_q, illegal_q, timeout_q;
  logic             retire, set_illegal, set_timeout;
  ctrl_t            ctrl;

  instr_classifier u_classifier (
    .opcode      (opcode),
    .instr_class (dec_class)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded strobes; ready/zero gate the completion strobes.
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    wait_d      = wait_q;
    ctrl        = '0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ctrl.imem_req = 1'b1;
        if (imem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          set_timeout = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        cls_d = dec_class;
        unique case (dec_class)
          CLS_RTYPE, CLS_LOAD, CLS_STORE: state_d = S_EXEC;
          CLS_CBZ:                        state_d = S_BRANCH;
          CLS_HALT:                       state_d = S_HALT;
          default: begin
            set_illegal = 1'b1;
            state_d     = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        if (cls_q == CLS_RTYPE) begin
          ctrl.aluop = ALUOP_RTYPE;
          state_d    = S_WB;
        end else begin
          ctrl.alusrc = 1'b1;
          ctrl.aluop  = ALUOP_ADD;
          state_d     = S_MEM;
        end
      end
      S_MEM: begin
        // Address path held steady for the whole wait.
        ctrl.alusrc = 1'b1;
        ctrl.aluop  = ALUOP_ADD;
        if (cls_q == CLS_STORE) begin
          ctrl.reg2loc    = 1'b1;
          ctrl.dmem_write = 1'b1;
        end else begin
          ctrl.dmem_read = 1'b1;
        end
        if (dmem_ready) begin
          if (cls_q == CLS_STORE) retire = 1'b1;
          else                    state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          set_timeout = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = (cls_q == CLS_LOAD);
        retire        = 1'b1;
      end
      S_BRANCH: begin
        ctrl.reg2loc  = 1'b1;
        ctrl.aluop    = ALUOP_PASS;
        ctrl.pc_src   = 1'b1;
        ctrl.pc_write = zero;
        retire        = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (retire) state_d = start ? S_FETCH : S_IDLE;
    if (state_d != state_q) wait_d = '0;
  end

  // Latched class, stall counter, sticky status and retire counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cls_q     <= CLS_RTYPE;
      wait_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      halted_q  <= halted_q | (state_d == S_HALT);
      illegal_q <= illegal_q | set_illegal;
      timeout_q <= timeout_q | set_timeout;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign imem_req    = ctrl.imem_req;
  assign ir_write    = ctrl.ir_write;
  assign pc_write    = ctrl.pc_write;
  assign pc_src      = ctrl.pc_src;
  assign reg2loc     = ctrl.reg2loc;
  assign alusrc      = ctrl.alusrc;
  assign aluop       = ctrl.aluop;
  assign dmem_read   = ctrl.dmem_read;
  assign dmem_write  = ctrl.dmem_write;
  assign memtoreg    = ctrl.memtoreg;
  assign regwrite    = ctrl.regwrite;
  assign state       = STATE_W'(state_q);
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = count_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences the LEGv8 datapath (PC, register bank, ALU, data memory) over multiple cycles per instruction, replacing single-cycle combinational control.
- Handshakes with variable-latency instruction and data memories, drives all datapath select/enable strobes, and reports halt, illegal-opcode and timeout status.

Parameters:
- STALL_LIMIT, 15, max cycles a memory request may wait for ready before timeout (1..255)
- CNT_W, 32, width of retired-instruction counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  run enable; level-sensitive
- opcode  in  11  instruction[31:21] from instruction register
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction memory ack
- dmem_ready  in  1  data memory ack
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load instruction register
- pc_write  out  1  PC load enable
- pc_src  out  1  0=PC+4, 1=branch target
- reg2loc  out  1  register read-port-2 address select (1=instr[4:0])
- alusrc  out  1  0=register, 1=sign-extended immediate
- aluop  out  2  00=add, 01=pass/zero-test, 10=R-type funct
- dmem_read  out  1  data memory read request
- dmem_write  out  1  data memory write request
- memtoreg  out  1  writeback select (1=memory)
- regwrite  out  1  register bank write enable
- state  out  3  current FSM state encoding
- halted  out  1  sticky, in HALT
- illegal  out  1  sticky, undecodable opcode seen
- timeout  out  1  sticky, memory stall limit exceeded
- instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (reset=0, async): state=IDLE; all strobes 0; aluop=00; halted/illegal/timeout=0; instr_count=0; wait counter=0.
- States: IDLE(0) FETCH(1) DECODE(2) EXEC(3) MEM(4) WB(5) BRANCH(6) HALT(7).
- IDLE: all strobes 0; start=1 -> FETCH next cycle.
- FETCH: imem_req=1 held until imem_ready. In the imem_ready cycle: ir_write=1, pc_write=1, pc_src=0, -> DECODE. Datapath holds fetch-time PC for branch target.
- DECODE (1 cycle, strobes 0): classify opcode:
  - R-type ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550 -> EXEC
  - LDUR 0x7C2, STUR 0x7C0 -> EXEC
  - CBZ (opcode[10:3]=0xB4) -> BRANCH
  - 0x7FF -> HALT
  - otherwise: illegal set, -> HALT
- EXEC: R-type: alusrc=0, reg2loc=0, aluop=10 -> WB. LDUR/STUR: alusrc=1, aluop=00 -> MEM.
- MEM: alusrc=1, aluop=00 held. LDUR: dmem_read=1 until dmem_ready -> WB. STUR: reg2loc=1, dmem_write=1 until dmem_ready -> retire. Request stays asserted and address stays stable while waiting.
- WB: regwrite=1 for exactly 1 cycle; memtoreg=1 for LDUR, 0 for R-type -> retire.
- BRANCH: reg2loc=1, alusrc=0, aluop=01, pc_src=1, pc_write=zero -> retire.
- Retire: instr_count+1 (wraps at 2^CNT_W). Next state is FETCH if start=1, else IDLE. Deasserting start mid-instruction never aborts it.
- Zero-wait latencies: R-type 4, LDUR 5, STUR 4, CBZ 3 cycles.
- Wait counter:
  - Counts cycles in FETCH/MEM while ready=0; clears on every state change.
  - Reaching STALL_LIMIT with ready still 0: timeout=1, request dropped next cycle, -> HALT.
  - Ready arriving in the same cycle the limit is reached counts as success.
- HALT: all strobes 0, halted=1; exits only via reset. HALT is not counted as retire.
- Strobes are Moore/state-decoded except ir_write/pc_write in FETCH, dmem completion, and pc_write in BRANCH, which are gated combinationally by ready/zero.
- Reset mid-operation: immediate return to reset values; pending memory request drops asynchronously.

Decomposition:
- Shared package multicycle_pkg: state enum/encodings, opcode constants (ADD, SUB, AND, ORR, LDUR, STUR, CBZ prefix, HALT), aluop encodings, instruction-class enum.
- One sub-module: instr_classifier, combinational opcode -> class {RTYPE, LOAD, STORE, CBZ, HALT, ILLEGAL}.

Test Plan:
- Reset then start=1, opcode=0x458, zero-wait memories -> states 1,2,3,5,1. regwrite=1 in WB with memtoreg=0, aluop=10 in EXEC, instr_count=1.
- LDUR 0x7C2, dmem_ready delayed 3 cycles -> dmem_read high 4 cycles in MEM, then WB with memtoreg=1, regwrite=1. Total 8 cycles.
- CBZ with zero=1, then with zero=0 -> pc_write=1, pc_src=1 in BRANCH for the first; pc_write=0 for the second. Each takes 3 cycles.
- opcode 0x123 -> illegal=1, halted=1, state=7. Strobes stay 0 for 20 cycles; instr_count unchanged.
- STALL_LIMIT=4, imem_ready stuck 0 -> timeout=1 after 4 FETCH cycles, imem_req=0 afterwards, state=7.
- Async reset asserted mid-MEM of STUR -> dmem_write=0 and state=0 without waiting for a clock edge. Deassert with start=1 -> FETCH next edge.
